// File: rtl/hamming_dec_engine.sv
// Memory-walking Hamming(16,11) SECDED decoder: reads NUM_MSG codewords, writes payload + status.
// Optional error statistics counters enabled by defining HAMMING_DEC_STATS_EN.
module hamming_dec_engine #(
  parameter int unsigned NUM_MSG  = 15,
  parameter int unsigned SRC_BASE = 30,
  parameter int unsigned DST_BASE = 0,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
`ifdef HAMMING_DEC_STATS_EN
  ,
  output logic [7:0]        sec_cnt,
  output logic [7:0]        ded_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    DECODE,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] SRC  = SRC_BASE[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] DST  = DST_BASE[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO  = ADDR_W'(2);
  localparam logic [6:0]        LAST = 7'(NUM_MSG - 1);

  state_t            state;
  logic [6:0]        msg;
  logic              start_q;
  logic [15:0]       cw;
  logic [2:0]        hi_q;
  logic [1:0]        flag_q;
  logic [ADDR_W-1:0] msg_off;

  logic [3:0]        syn;
  logic              par;
  logic [15:0]       fixed;
  logic [10:0]       dec;
  logic [1:0]        flag;

  assign msg_off = ADDR_W'({msg, 1'b0});

  always_comb begin
    syn = '0;
    for (int unsigned k = 1; k < 16; k++) begin
      syn = syn ^ ({4{cw[k]}} & 4'(k));
    end
    par   = ^cw;
    fixed = cw;
    if (syn != '0 && par) begin
      fixed[syn] = ~cw[syn];
    end
    dec = {fixed[15:9], fixed[7:5], fixed[3]};
    if (syn == '0 && !par) begin
      flag = 2'b00;
    end else if (par) begin
      flag = 2'b01;
    end else begin
      flag = 2'b10;
    end
  end

  // Start is armed for one cycle before RD_LO, so a run spans 5*NUM_MSG+1 edges from the Start edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      Ack       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      msg       <= '0;
      start_q   <= 1'b0;
      cw        <= '0;
      hi_q      <= '0;
      flag_q    <= '0;
`ifdef HAMMING_DEC_STATS_EN
      sec_cnt   <= '0;
      ded_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          mem_we <= 1'b0;
          if (start_q) begin
            start_q  <= 1'b0;
            msg      <= '0;
            mem_addr <= SRC;
            state    <= RD_LO;
          end else if (Start) begin
            start_q <= 1'b1;
            Ack     <= 1'b0;
`ifdef HAMMING_DEC_STATS_EN
            sec_cnt <= '0;
            ded_cnt <= '0;
`endif
          end
        end
        RD_LO: begin
          cw[7:0]  <= mem_rdata;
          mem_addr <= mem_addr + ONE;
          state    <= RD_HI;
        end
        RD_HI: begin
          cw[15:8] <= mem_rdata;
          state    <= DECODE;
        end
        DECODE: begin
          hi_q      <= dec[10:8];
          flag_q    <= flag;
          mem_addr  <= DST + msg_off;
          mem_wdata <= dec[7:0];
          mem_we    <= 1'b1;
          state     <= WR_LO;
        end
        WR_LO: begin
          mem_addr  <= mem_addr + ONE;
          mem_wdata <= {flag_q, 3'b000, hi_q};
          state     <= WR_HI;
        end
        WR_HI: begin
          mem_we <= 1'b0;
`ifdef HAMMING_DEC_STATS_EN
          if (flag_q == 2'b01 && sec_cnt != 8'hFF) sec_cnt <= sec_cnt + 8'd1;
          if (flag_q == 2'b10 && ded_cnt != 8'hFF) ded_cnt <= ded_cnt + 8'd1;
`endif
          if (msg == LAST) begin
            Ack   <= 1'b1;
            state <= DONE;
          end else begin
            msg      <= msg + 7'd1;
            mem_addr <= SRC + msg_off + TWO;
            state    <= RD_LO;
          end
        end
        default: begin
          mem_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
